// File: rtl/mempy_mult_rom.sv
// ---------------------------------------------------------------------------
// mempy_mult_rom
//   Table-based multiplier. The address holds two N/2-bit unsigned operands
//   {op_a, op_b}; the addressed word is their N-bit product. The table is a
//   constant elaborated at build time, with no write path, and the read
//   data is registered (one clock of latency, full throughput).
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (release synchronised internally)
//   address  {op_a, op_b}, op_a = address[N-1:N/2], op_b = address[N/2-1:0]
//   read_en  read request, only looked at while ce=1
//   ce       chip enable; ce=0 clears data on the next edge
//   data     registered read data
// ---------------------------------------------------------------------------
module mempy_mult_rom #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] address,
  input  logic         read_en,
  input  logic         ce,
  output logic [N-1:0] data
);

  localparam int H     = N / 2;
  localparam int DEPTH = 2 ** N;

  // Constant product table. Each entry is a product of two H-bit values,
  // which always fits in N bits, so the cast never drops significant bits.
  logic [N-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [N-1:0] PROD = N'((k / (2 ** H)) * (k % (2 ** H)));
    assign rom[k] = PROD;
  end

  // Release synchroniser: rdy goes high on the first edge after rst_n
  // rises, so the earliest captured read lands on the second edge.
  logic rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy <= 1'b0;
    else        rdy <= 1'b1;
  end

  // The address is only indexed on the read branch, so an unknown address
  // while disabled or idle never reaches data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           data <= '0;
    else if (!rdy || !ce) data <= '0;
    else if (read_en)     data <= rom[address];
  end

endmodule

// File: tb/tb_mempy_mult_rom.sv
module tb_mempy_mult_rom;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] address;
  logic       read_en;
  logic       ce;
  logic [7:0] data;

  int total = 0;
  int bad   = 0;

  logic [7:0] sb_q [$];
  logic [7:0] exp_v;

  mempy_mult_rom #(.N(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .address (address),
    .read_en (read_en),
    .ce      (ce),
    .data    (data)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; read_en = 1'b1; address = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(8'h00);
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (data !== exp_v) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, data, exp_v);
      end
    end
    // release between edges; first edge must still give 0, second the read
    rst_n = 1'b1;
    sb_q.push_back(8'h00);
    sb_q.push_back(8'hE1);
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (data !== exp_v) begin
        bad++;
        $display("FAIL reset_release edge=%0d got=%h want=%h", i + 1, data, exp_v);
      end
    end
  endtask

  task automatic test_reads();
    logic [7:0] a_tab [4] = '{8'h37, 8'hFF, 8'hA5, 8'h00};
    logic [7:0] e_tab [4] = '{8'h15, 8'hE1, 8'h32, 8'h00};
    ce = 1'b1; read_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      address = a_tab[i];
      sb_q.push_back(e_tab[i]);
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (data !== exp_v) begin
        bad++;
        $display("FAIL table_read addr=%h got=%h want=%h", a_tab[i], data, exp_v);
      end
    end
  endtask

  task automatic test_sweep();
    int drv;
    logic [7:0] a;
    ce = 1'b1; read_en = 1'b1;
    for (int i = 0; i <= 256; i++) begin
      drv = (i < 256) ? i : 'h137;
      a = drv[7:0];
      address = a;
      if (i < 256) sb_q.push_back(8'((i / 16) * (i % 16)));
      else         sb_q.push_back(8'h15);
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (data !== exp_v) begin
        bad++;
        $display("FAIL sweep idx=%h got=%h want=%h", drv, data, exp_v);
      end
    end
  endtask

  task automatic test_gating();
    logic       ce_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       re_t [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] ad_t [4] = '{8'hFF, 8'h37, 8'hA5, 8'h37};
    logic [7:0] ex_t [4] = '{8'hE1, 8'hE1, 8'hE1, 8'h00};
    for (int i = 0; i < 4; i++) begin
      ce = ce_t[i]; read_en = re_t[i]; address = ad_t[i];
      sb_q.push_back(ex_t[i]);
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (data !== exp_v) begin
        bad++;
        $display("FAIL gating step=%0d got=%h want=%h", i, data, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a_tab [3] = '{8'hA5, 8'h37, 8'hFF};
    logic [7:0] e_tab [3] = '{8'h32, 8'h15, 8'hE1};
    ce = 1'b1; read_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      address = a_tab[i];
      sb_q.push_back(e_tab[i]);
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (data !== exp_v) begin
        bad++;
        $display("FAIL stream addr=%h got=%h want=%h", a_tab[i], data, exp_v);
      end
    end
    // assert reset between edges with a read of 0xFF in flight
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (data !== 8'h00) begin
      bad++;
      $display("FAIL async_clear got=%h want=00", data);
    end
    tick();
    total++;
    if (data !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset_hold got=%h want=00", data);
    end
    rst_n = 1'b1;
    address = 8'h5B;  // 5*11
    sb_q.push_back(8'h00);
    sb_q.push_back(8'h37);
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (data !== exp_v) begin
        bad++;
        $display("FAIL mid_release edge=%0d got=%h want=%h", i + 1, data, exp_v);
      end
    end
  endtask

  task automatic test_unknown();
    ce = 1'b0; read_en = 1'b1; address = 8'bx;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(8'h00);
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (data !== exp_v) begin
        bad++;
        $display("FAIL x_addr_ce0 cyc=%0d got=%h want=%h", i, data, exp_v);
      end
    end
    ce = 1'b1; address = 8'h37;
    sb_q.push_back(8'h15);
    tick();
    exp_v = sb_q.pop_front();
    total++;
    if (data !== exp_v) begin
      bad++;
      $display("FAIL x_pre_read got=%h want=%h", data, exp_v);
    end
    read_en = 1'b0; address = 8'bx;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(8'h15);
      tick();
      exp_v = sb_q.pop_front();
      total++;
      if (data !== exp_v) begin
        bad++;
        $display("FAIL x_addr_hold cyc=%0d got=%h want=%h", i, data, exp_v);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; read_en = 1'b0; address = 8'h00;
    test_reset();
    test_reads();
    test_sweep();
    test_gating();
    test_reset_mid();
    test_unknown();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mempy_mult_rom.md
Name: mempy_mult_rom

Overview:
- Read-only lookup memory holding the precomputed product table for the automated multiplication device.
- The address is split into two N/2-bit unsigned operands. The addressed word is their N-bit product.
- The table contents are generated offline by script and compiled into RTL as a constant table.
- Sits between operand registers and the result path as a table-based multiplier.

Parameters:
- N, 8, address width and data width in bits. Must be even; each operand is N/2 bits.

Ports:
- clk      input   1   system clock, rising-edge active
- rst_n    input   1   asynchronous active-low reset
- address  input   N   {op_a, op_b}: op_a = address[N-1:N/2], op_b = address[N/2-1:0]
- read_en  input   1   read request, sampled only while ce=1
- ce       input   1   chip enable
- data     output  N   registered read data

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- Table contents:
  - ROM[k] = op_a * op_b (unsigned), for k = 0 .. 2^N-1.
  - The product of two N/2-bit values always fits in N bits, so there is no overflow and no truncation.
  - Contents are constant and have no write path.
- Reset:
  - rst_n=0 clears data to 0 immediately, without waiting for a clock edge.
  - data stays 0 while rst_n is held low.
  - Deassertion is synchronised internally: the first read can be captured on the second rising edge after rst_n rises. Any edge before that leaves data at 0.
- Read, ce=1 and read_en=1: on the rising clk edge, data <= ROM[address]. Latency is one clock. No handshake or stall.
- Hold, ce=1 and read_en=0: data holds its previous value.
- Disable, ce=0: data is cleared to 0 on the next rising edge, regardless of read_en.
- Back-to-back reads: every cycle with ce=1 and read_en=1 returns a new word. Full throughput.
- Address width: address is exactly N bits. A wider driver is truncated by the connection, so an index of 2^N+k reads ROM[k].
- Reset mid-read: asynchronous clear wins. The read in flight is discarded and is not replayed after reset.
- X/Z on address while ce=0 or read_en=0 must not propagate to data.
- Implementation: a registered case-ROM or a constant array of 2^N entries. A synthesisable combinational multiply is also acceptable if it is bit-identical to the table.

Test Plan:
- Reset: rst_n=0 with ce=1, read_en=1, address=0xFF -> data=0x00 asynchronously, and it stays 0 while reset is held.
- Table reads:
  - address=0x37, ce=1, read_en=1 -> data=0x15 (3*7) one clk later.
  - address=0xFF -> data=0xE1 (15*15).
  - address=0xA5 -> data=0x32 (10*5).
  - address=0x00 -> data=0x00.
- Exhaustive sweep: all 256 addresses back-to-back with ce=1, read_en=1 -> each data equals address[7:4]*address[3:0], one cycle late. A driver index of 0x137 reads ROM[0x37] = 0x15.
- Enable gating:
  - After reading 0xE1, set read_en=0 with ce=1 and change address -> data holds 0xE1.
  - Then set ce=0 -> data=0x00 on the next edge.
- Reset mid-operation: assert rst_n=0 while streaming reads -> data=0x00 immediately. After release, the first valid read appears on the second post-release edge, with the correct product.
- Unknowns: address=X with ce=0 -> data stays 0x00, with no X on the output.
